// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, the slave FSM state type and byte-enable decode
// used by ahbl_sram_slave and its write buffer.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_STALL = 3'd2,
        ST_ERR1  = 3'd3,
        ST_ERR2  = 3'd4
    } ahbl_state_e;

    // Sizes above word are treated as a full word.
    function automatic logic [3:0] be_decode(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahbl_wbuf.sv
// One-entry posted write buffer: holds {addr, BE, data}, requests a drain while
// valid, and merges its bytes over SRAM read data for a matching word.
module ahbl_wbuf
    import ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_be,
    input  logic [31:0]   load_data,
    input  logic          drain_ack,
    output logic          drain_req,
    output logic [AW-1:0] wb_addr,
    output logic [3:0]    wb_be,
    output logic [31:0]   wb_data,
    input  logic [AW-1:0] fwd_addr,
    input  logic [31:0]   fwd_rdata,
    output logic [31:0]   fwd_data
);

    logic          wb_valid_reg;
    logic [AW-1:0] wb_addr_reg;
    logic [3:0]    wb_be_reg;
    logic [31:0]   wb_data_reg;
    logic          fwd_match;

    // A load on the same edge as a drain keeps the buffer occupied.
    always_ff @(posedge clk) begin
        if (srst) begin
            wb_valid_reg <= 1'b0;
        end else if (load) begin
            wb_valid_reg <= 1'b1;
        end else if (drain_ack) begin
            wb_valid_reg <= 1'b0;
        end
        if (load) begin
            wb_addr_reg <= load_addr;
            wb_be_reg   <= load_be;
            wb_data_reg <= load_data;
        end
    end

    assign drain_req = wb_valid_reg;
    assign wb_addr   = wb_addr_reg;
    assign wb_be     = wb_be_reg;
    assign wb_data   = wb_data_reg;
    assign fwd_match = wb_valid_reg && (wb_addr_reg == fwd_addr);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign fwd_data[8*gi +: 8] = (fwd_match && wb_be_reg[gi]) ? wb_data_reg[8*gi +: 8]
                                                                     : fwd_rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave in front of a 1-cycle synchronous SRAM with a posted write buffer.
// Define AHBL_SRAM_RANGE_CHECK_EN to answer out-of-range transfers with an ERROR.
module ahbl_sram_slave
    import ahbl_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          SRAMCS,
    output logic [3:0]    SRAMWEN,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    input  logic [31:0]   SRAMRDATA
);

    ahbl_state_e   state_reg, state_next;
    logic          dp_write_reg, dp_in_range_reg;
    logic [AW-1:0] dp_addr_reg;
    logic [3:0]    dp_be_reg;

    logic [AW-1:0] haddr_word;
    logic          haddr_in_range, addr_accept, range_err, read_issue;
    logic          conflict, wb_load, drain_req, drain_ack;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_be;
    logic [31:0]   fwd_data;
    logic          unused_bits;

    assign unused_bits    = ^{HADDR[31:AW+2], HTRANS[0]};
    assign haddr_word     = HADDR[AW+1:2];
    assign haddr_in_range = {1'b0, haddr_word} < (AW+1)'(DEPTH);
    assign addr_accept    = HSEL & HREADY & HTRANS[1] & ~HRESET;
    assign read_issue     = addr_accept & ~HWRITE & haddr_in_range;

`ifdef AHBL_SRAM_RANGE_CHECK_EN
    assign range_err = addr_accept & ~haddr_in_range;
`else
    assign range_err = 1'b0;
`endif

    // Uses the raw address-phase request, not HREADY, since HREADY reflects our own HREADYOUT here.
    assign conflict = (state_reg == ST_DATA) & dp_write_reg & dp_in_range_reg & drain_req
                    & HSEL & HTRANS[1] & ~HWRITE & haddr_in_range & ~HRESET;
    assign wb_load  = ~HRESET & dp_write_reg & dp_in_range_reg
                    & (((state_reg == ST_DATA) & ~conflict) | (state_reg == ST_STALL));
    assign drain_ack = drain_req & ~read_issue & ~HRESET;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg       <= ST_IDLE;
            dp_write_reg    <= 1'b0;
            dp_in_range_reg <= 1'b0;
            dp_addr_reg     <= '0;
            dp_be_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (addr_accept) begin
                dp_write_reg    <= HWRITE;
                dp_in_range_reg <= haddr_in_range;
                dp_addr_reg     <= haddr_word;
                dp_be_reg       <= be_decode(HSIZE, HADDR[1:0]);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                if (conflict)         state_next = ST_STALL;
                else if (range_err)   state_next = ST_ERR1;
                else if (addr_accept) state_next = ST_DATA;
                else                  state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        case (state_reg)
            ST_DATA: begin
                if (conflict) HREADYOUT = 1'b0;
                if (!dp_write_reg && dp_in_range_reg) HRDATA = fwd_data;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
        // Reads own the SRAM port; the buffer drains in any other cycle.
        SRAMCS   = 1'b0;
        SRAMWEN  = 4'b0000;
        SRAMADDR = wb_addr;
        if (read_issue) begin
            SRAMCS   = 1'b1;
            SRAMADDR = haddr_word;
        end else if (drain_ack) begin
            SRAMCS  = 1'b1;
            SRAMWEN = wb_be;
        end
    end

    ahbl_wbuf #(.AW(AW)) u_wbuf (
        .clk       (HCLK),
        .srst      (HRESET),
        .load      (wb_load),
        .load_addr (dp_addr_reg),
        .load_be   (dp_be_reg),
        .load_data (HWDATA),
        .drain_ack (drain_ack),
        .drain_req (drain_req),
        .wb_addr   (wb_addr),
        .wb_be     (wb_be),
        .wb_data   (SRAMWDATA),
        .fwd_addr  (dp_addr_reg),
        .fwd_rdata (SRAMRDATA),
        .fwd_data  (fwd_data)
    );

endmodule
